// File: rtl/pack_round_if.sv
// pack_round_if: handshake and data bundle for the pack_round result packer.
//   master : upstream/downstream side (drives enable, the input beat and out_ready)
//   slave  : pack_round side (drives in_ready and the registered output beat)
// Signals
//   enable, round_mode, in_valid/in_ready, sign_in, exp_in (signed, unbiased),
//   mant_in {hidden, fraction, G, S}, is_nan/pinf/ninf_in, result_in,
//   out_valid/out_ready, out_data, is_nan/pinf/ninf_out, result_out,
//   inexact_out, overflow_out, underflow_out
interface pack_round_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic                    enable;
  logic                    round_mode;
  logic                    in_valid;
  logic                    in_ready;
  logic                    sign_in;
  logic signed [EXP_W+1:0] exp_in;
  logic [FRAC_W+2:0]       mant_in;
  logic                    is_nan_in;
  logic                    is_pinf_in;
  logic                    is_ninf_in;
  logic                    result_in;

  logic                    out_valid;
  logic                    out_ready;
  logic [W-1:0]            out_data;
  logic                    is_nan_out;
  logic                    is_pinf_out;
  logic                    is_ninf_out;
  logic                    result_out;
  logic                    inexact_out;
  logic                    overflow_out;
  logic                    underflow_out;

  modport master (
    output enable, round_mode, in_valid, sign_in, exp_in, mant_in,
           is_nan_in, is_pinf_in, is_ninf_in, result_in, out_ready,
    input  in_ready, out_valid, out_data, is_nan_out, is_pinf_out,
           is_ninf_out, result_out, inexact_out, overflow_out, underflow_out
  );

  modport slave (
    input  enable, round_mode, in_valid, sign_in, exp_in, mant_in,
           is_nan_in, is_pinf_in, is_ninf_in, result_in, out_ready,
    output in_ready, out_valid, out_data, is_nan_out, is_pinf_out,
           is_ninf_out, result_out, inexact_out, overflow_out, underflow_out
  );
endinterface

// File: rtl/pack_round.sv
// pack_round: packs a normalised sign / unbiased exponent / extended mantissa
// result of the square-root datapath into an IEEE-754 word (FP16 by default).
// Two pipeline stages with valid/ready back-pressure:
//   stage 1 biases the exponent and denormalises tiny results (sticky kept),
//   stage 2 rounds (RNE or truncate), saturates on overflow and packs.
// Ports
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : pack_round_if.slave (handshakes, input beat, output word and flags)
module pack_round #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input logic         clk,
  input logic         rst,
  pack_round_if.slave bus
);
  localparam int EW   = EXP_W + 2;   // signed working exponent width
  localparam int MW   = FRAC_W + 3;  // hidden + fraction + G + S
  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 2;

  typedef enum logic [1:0] {K_NUM, K_NAN, K_PINF, K_NINF} kind_t;

  // Stage 1 registers
  logic          s1_valid;
  logic          s1_sign;
  logic          s1_rtz;
  logic          s1_tiny;
  logic          s1_ovf;
  logic [EW-1:0] s1_e;
  logic [MW-1:0] s1_sig;
  kind_t         s1_kind;
  logic [3:0]    s1_tags;  // {nan, pinf, ninf, result} passed through untouched

  // Pipeline control: stage 2 can take a new beat when empty or draining.
  logic adv2;
  logic load1;

  assign adv2        = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = bus.enable & (!s1_valid | adv2);
  assign load1       = bus.in_valid & bus.in_ready;

  // ---------------- Stage 1: bias and align ----------------
  logic signed [EW-1:0] e_b;
  logic [EW-1:0]        shift;
  logic [MW-1:0]        lost_mask;
  logic [MW-1:0]        sig_d;
  logic [EW-1:0]        e_d;
  logic                 tiny_d;
  logic                 ovf_d;
  logic                 zero_d;
  kind_t                kind_d;

  always_comb begin
    // NOTE: every variable gets a default at the top of the block so that no
    // branch leaves it unassigned, which would otherwise infer a latch.
    e_b       = bus.exp_in + EW'(BIAS);
    shift     = EW'(1) - e_b;
    zero_d    = (bus.mant_in == '0);
    tiny_d    = (e_b <= 0);
    ovf_d     = !zero_d && (e_b > EMAX);
    lost_mask = '0;
    sig_d     = bus.mant_in;
    e_d       = e_b;

    if (zero_d) begin
      sig_d = '0;
      e_d   = '0;
    end else if (tiny_d) begin
      e_d = '0;
      if (int'(shift) >= MW) begin
        // Everything shifts out; only the sticky survives (mantissa is non-zero).
        sig_d = MW'(1);
      end else begin
        lost_mask = ~({MW{1'b1}} << shift);
        sig_d     = (bus.mant_in >> shift) | MW'(|(bus.mant_in & lost_mask));
      end
    end

    if (bus.is_nan_in)       kind_d = K_NAN;
    else if (bus.is_pinf_in) kind_d = K_PINF;
    else if (bus.is_ninf_in) kind_d = K_NINF;
    else                     kind_d = K_NUM;
  end

  // ---------------- Stage 2: round and pack ----------------
  logic                inc_near;
  logic                inc;
  logic                carry_near;
  logic [FRAC_W+1:0]   sum;
  logic [EW:0]         e_near;
  logic [EXP_W-1:0]    e_fld;
  logic [W-1:0]        data_d;
  logic                inexact_d;
  logic                overflow_d;
  logic                underflow_d;

  always_comb begin
    // lsb = sig[2], G = sig[1], S = sig[0]
    inc_near = s1_sig[1] & (s1_sig[0] | s1_sig[2]);
    inc      = inc_near & !s1_rtz;
    sum      = {1'b0, s1_sig[MW-1:2]} + (FRAC_W+2)'(inc);

    // Overflow is judged on the nearest-rounded exponent in both modes, so a
    // truncated result that would have carried to infinity still reports it.
    carry_near = inc_near & (&s1_sig[MW-1:2]);
    e_near     = {1'b0, s1_e} + (EW+1)'(carry_near);

    e_fld = s1_e[EXP_W-1:0];
    if (sum[FRAC_W+1])                    e_fld = e_fld + 1'b1;     // carry past hidden bit
    else if (s1_e == '0 && sum[FRAC_W])   e_fld = EXP_W'(1);        // subnormal rounds to min normal

    inexact_d   = s1_sig[1] | s1_sig[0];
    overflow_d  = s1_ovf | (e_near > (EW+1)'(EMAX));
    underflow_d = s1_tiny & inexact_d;
    data_d      = {s1_sign, e_fld, sum[FRAC_W-1:0]};

    if (overflow_d) begin
      inexact_d = 1'b1;
      data_d    = s1_rtz ? {s1_sign, EXP_W'(EMAX), {FRAC_W{1'b1}}}
                         : {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end

    if (s1_kind != K_NUM) begin
      inexact_d   = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    unique case (s1_kind)
      K_NAN:   data_d = {1'b1, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
      K_PINF:  data_d = {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      K_NINF:  data_d = {1'b1, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      default: ;
    endcase
  end

  // ---------------- Registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    if (rst) begin
      // NOTE: the stage-1 payload is reset along with the valids; it is only a
      // handful of flops and keeps every register at a known value after reset.
      s1_valid          <= 1'b0;
      s1_sign           <= 1'b0;
      s1_rtz            <= 1'b0;
      s1_tiny           <= 1'b0;
      s1_ovf            <= 1'b0;
      s1_e              <= '0;
      s1_sig            <= '0;
      s1_kind           <= K_NUM;
      s1_tags           <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_data      <= '0;
      bus.is_nan_out    <= 1'b0;
      bus.is_pinf_out   <= 1'b0;
      bus.is_ninf_out   <= 1'b0;
      bus.result_out    <= 1'b0;
      bus.inexact_out   <= 1'b0;
      bus.overflow_out  <= 1'b0;
      bus.underflow_out <= 1'b0;
    end else if (!bus.enable) begin
      // Synchronous flush: in-flight beats are discarded.
      s1_valid          <= 1'b0;
      bus.out_valid     <= 1'b0;
      bus.out_data      <= '0;
      bus.is_nan_out    <= 1'b0;
      bus.is_pinf_out   <= 1'b0;
      bus.is_ninf_out   <= 1'b0;
      bus.result_out    <= 1'b0;
      bus.inexact_out   <= 1'b0;
      bus.overflow_out  <= 1'b0;
      bus.underflow_out <= 1'b0;
    end else begin
      if (load1) begin
        s1_valid <= 1'b1;
        s1_sign  <= bus.sign_in;
        s1_rtz   <= bus.round_mode;
        s1_tiny  <= tiny_d;
        s1_ovf   <= ovf_d;
        s1_e     <= e_d;
        s1_sig   <= sig_d;
        s1_kind  <= kind_d;
        s1_tags  <= {bus.is_nan_in, bus.is_pinf_in, bus.is_ninf_in, bus.result_in};
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end

      if (adv2) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_data      <= data_d;
          bus.is_nan_out    <= s1_tags[3];
          bus.is_pinf_out   <= s1_tags[2];
          bus.is_ninf_out   <= s1_tags[1];
          bus.result_out    <= s1_tags[0];
          bus.inexact_out   <= inexact_d;
          bus.overflow_out  <= overflow_d;
          bus.underflow_out <= underflow_d;
        end
      end
    end
  end
endmodule

// File: doc/pack_round.md
# pack_round

Parametrised result-packing stage for the iterative floating-point square-root datapath. It sits after the iteration core and converts a normalised sign/unbiased-exponent/extended-mantissa result into an IEEE-754 binary word of configurable format (FP16 by default; BF16 and FP32 via parameters). It adds four things to the earlier FP16-only packer:
- round-to-nearest-even or truncate mode,
- overflow saturation,
- subnormal rounding with exception flags,
- a 2-stage valid/ready pipeline with back-pressure.

## Interface
Parameters:
- EXP_W, 5, exponent field width; BIAS = 2^(EXP_W-1)-1, EMAX = 2^EXP_W-2
- FRAC_W, 10, stored fraction width; total word width W = 1+EXP_W+FRAC_W

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- enable  in  1  low = synchronous flush of both stages, in_ready=0
- round_mode  in  1  0 = round-to-nearest-even (RNE), 1 = truncate (RTZ); sampled with each input beat
- in_valid  in  1  input beat valid
- in_ready  out  1  stage 1 can accept a beat
- sign_in  in  1  result sign
- exp_in  in  EXP_W+2 (signed)  unbiased exponent
- mant_in  in  FRAC_W+3  bit: [FRAC_W+2] hidden, then FRAC_W fraction, then guard G, then sticky S
- is_nan_in, is_pinf_in, is_ninf_in  in  1 each  special-case tags, priority NaN > +inf > -inf
- result_in  in  1  sideband tag, passed through unchanged
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  W  packed word
- is_nan_out, is_pinf_out, is_ninf_out, result_out  out  1 each  tags aligned with out_data
- inexact_out, overflow_out, underflow_out  out  1 each  exception flags aligned with out_data

## Operation
- Stage 1 (align):
  - e_b = exp_in + BIAS, computed at EXP_W+2 bits signed.
  - Normal case, e_b >= 1: sig = mant_in, e = e_b.
  - Subnormal case, e_b <= 0: shift = 1-e_b; sig = mant_in >> shift; every bit shifted out is ORed into sig[0]; e = 0.
  - If shift >= FRAC_W+3: sig = {0…, |mant_in}.
  - mant_in == 0 with no special tag: signed zero, e = 0.
  - Stage 1 also registers tiny = (e_b <= 0).
- Stage 2 (round and pack):
  - lsb = sig[2], G = sig[1], S = sig[0].
  - RNE increment inc = G & (S | lsb); RTZ inc = 0.
  - {hidden, frac} + inc is computed at FRAC_W+2 bits.
  - Carry past the hidden bit → e+1, frac = 0.
  - Subnormal rounding into hidden bit → e = 1 (minimum normal).
  - inexact = G|S.
  - underflow = tiny & inexact.
  - overflow = (e after rounding > EMAX), or e_b > EMAX on entry.
- Overflow result: RNE → {sign, all-ones, 0} (±inf); RTZ → {sign, EMAX, all-ones} (max finite). inexact is also set.
- Special results (all flags 0):
  - NaN → {1, all-ones, 1, 0…} (canonical quiet NaN, 0xFE00 in FP16).
  - +inf → {0, all-ones, 0}.
  - −inf → {1, all-ones, 0}.
- Tags, flags and result_out travel with their beat. No beat is dropped, duplicated or reordered.

## Timing
- Latency: 2 cycles from input handshake (in_valid & in_ready) to out_valid, when out_ready is held high. Throughput is 1 beat/cycle.
- Control equations:
  - adv2 = !out_valid | out_ready
  - Stage 1 → stage 2 transfer when s1_valid & adv2.
  - in_ready = enable & (!s1_valid | adv2). This is combinational from out_ready; no other combinational input-to-output paths.
- out_valid stays asserted with out_data and all flags stable until out_ready is seen high.
- Back-pressure: with out_ready low, at most 2 beats are held (stage 2 plus stage 1); in_ready then drops.
- Simultaneous input and output handshake on a full pipe: both complete in the same cycle.
- enable low at a clock edge: s1_valid, out_valid, out_data and all flags clear to 0 on that edge. In-flight beats are discarded.
- rst asserted (any time, asynchronously): every output register goes to 0 immediately and the pipeline empties. Values: out_valid=0, out_data=0, all tag and flag outputs 0.
- After reset: in_ready follows enable.

## Test plan
Default parameters (FP16) unless stated; mant_in values are shown as hidden_fraction_GS.
1. exp_in=0, mant_in=1_0000000000_00, RNE, out_ready=1 → out_data=0x3C00 two cycles after the handshake, inexact=0.
2. Ties, exp_in=0:
   - mant_in=1_0000000001_10, RNE → 0x3C02, inexact=1.
   - mant_in=1_0000000000_10, RNE → 0x3C00, inexact=1.
   - Both inputs with RTZ → 0x3C01 and 0x3C00 respectively.
3. Overflow, exp_in=15, mant_in=1_1111111111_10:
   - RNE → 0x7C00 (exponent carry to 31), overflow=1.
   - RTZ → 0x7BFF, overflow=1.
4. Subnormal boundaries:
   - exp_in=−15, mant_in=1_0000000000_00 → 0x0200, underflow=0.
   - exp_in=−24 → 0x0001, exact.
   - exp_in=−25 → 0x0000 under RNE tie-to-even, underflow=1, inexact=1.
   - exp_in=−15, mant_in=1_1111111111_11 → 0x0400 (rounds into minimum normal).
5. Back-pressure: drive 8 consecutive distinct beats while out_ready toggles 0/1 randomly, including a 4-cycle low stretch.
   - in_ready falls after 2 beats are held.
   - All 8 results emerge in order, none lost or repeated.
   - out_data is stable while stalled.
6. Specials and reset:
   - is_nan_in=1 → 0xFE00, is_nan_out=1.
   - is_ninf_in=1 → 0xFC00.
   - rst pulsed mid-stream between clock edges → out_valid and all outputs read 0 before the next edge, and no stale beat appears afterwards.
   - enable low for 1 cycle flushes the pipe identically.
